// File: rtl/uart_rx_if.sv
// Serial receive bus: the line in, received word plus status pulses out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  uartBus;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataValid;
  logic                  frameErr;
  logic                  busy;

  modport master (output uartBus, input dataOut, dataValid, frameErr, busy);
  modport slave  (input uartBus, output dataOut, dataValid, frameErr, busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, centre sampling, one stop bit, break-safe recovery.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLOCKS_PER_BIT = 10417
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_e;

  state_e                state_q;
  logic [1:0]            sync_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic                  line;

  assign line = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.uartBus};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: if (!line) begin
          cnt_q   <= '0;
          state_q <= START;
        end
        // Half-bit check rejects short glitches before committing to a frame.
        START: if (cnt_q == CNT_HALF) begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= line ? IDLE : DATA;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
        DATA: if (cnt_q == CNT_LAST) begin
          shift_q[idx_q[IDX_W-2:0]] <= line;
          idx_q <= idx_q + IDX_ONE;
          cnt_q <= '0;
          if (idx_q == IDX_LAST) state_q <= STOP;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
        STOP: if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          if (line) begin
            dout_q  <= shift_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= RECOVER;
          end
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
        // A held-low break parks here instead of re-triggering START.
        RECOVER: if (line) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dataOut   = dout_q;
  assign bus.dataValid = valid_q;
  assign bus.frameErr  = ferr_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit, 8 data bits; clock period 100 time units.
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int TCLK  = 100;
  localparam int TBIT  = CPB * TCLK;

  logic clk;
  logic rst;
  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #(TCLK/2) clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  int   vcnt = 0;
  int   fcnt = 0;
  int   both = 0;
  time  last_v_t = 0;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (bus.dataValid === 1'b1) begin
      vcnt++;
      last_v_t = $time;
      rxq.push_back(bus.dataOut);
    end
    if (bus.frameErr === 1'b1) fcnt++;
    if (bus.dataValid === 1'b1 && bus.frameErr === 1'b1) both++;
  end

  // Drives start, 8 data bits LSB first, then leaves the stop level on the line.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t);
    bus.uartBus = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      bus.uartBus = d[i];
      #(bit_t);
    end
    bus.uartBus = stop;
    #(bit_t);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.uartBus = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.dataOut !== 8'h00) begin errors++; $display("FAIL reset_dataOut got=%h exp=00", bus.dataOut); end
    checks++; if (bus.dataValid !== 1'b0) begin errors++; $display("FAIL reset_dataValid got=%b exp=0", bus.dataValid); end
    checks++; if (bus.frameErr !== 1'b0) begin errors++; $display("FAIL reset_frameErr got=%b exp=0", bus.frameErr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    int v0, f0;
    time t0;
    v0 = vcnt; f0 = fcnt; rxq.delete();
    @(negedge clk);
    t0 = $time;
    send_frame(8'hA5, 1'b1, TBIT);
    repeat (4) @(negedge clk);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count got=%0d exp=1", vcnt - v0); end
    checks++; if (bus.dataOut !== 8'hA5) begin errors++; $display("FAIL single_dataOut got=%h exp=a5", bus.dataOut); end
    checks++; if (fcnt - f0 !== 0) begin errors++; $display("FAIL single_frameErr_count got=%0d exp=0", fcnt - f0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", bus.busy); end
    // Decision at ~154.5 cycles after the fall, seen on the following negedge.
    checks++;
    if (last_v_t - t0 < 154 * TCLK || last_v_t - t0 > 156 * TCLK) begin
      errors++; $display("FAIL single_latency got=%0t exp=15500+-100", last_v_t - t0);
    end
  endtask

  task automatic test_back_to_back;
    int v0, f0;
    v0 = vcnt; f0 = fcnt; rxq.delete();
    @(negedge clk);
    send_frame(8'h3C, 1'b1, TBIT);
    send_frame(8'hFF, 1'b1, TBIT);
    repeat (4) @(negedge clk);
    checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got=%0d exp=2", vcnt - v0); end
    checks++; if (rxq.size() < 1 || rxq[0] !== 8'h3C) begin errors++; $display("FAIL b2b_first got=%h exp=3c", rxq.size() > 0 ? rxq[0] : 8'hxx); end
    checks++; if (rxq.size() < 2 || rxq[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got=%h exp=ff", rxq.size() > 1 ? rxq[1] : 8'hxx); end
    checks++; if (fcnt - f0 !== 0) begin errors++; $display("FAIL b2b_frameErr_count got=%0d exp=0", fcnt - f0); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = vcnt; f0 = fcnt;
    @(negedge clk);
    bus.uartBus = 1'b0;
    #(4 * TCLK);
    bus.uartBus = 1'b1;
    #(1 * TCLK);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid got=%b exp=1", bus.busy); end
    #(7 * TCLK);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle_by_12 got=%b exp=0", bus.busy); end
    repeat (4) @(negedge clk);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid_count got=%0d exp=0", vcnt - v0); end
    checks++; if (fcnt - f0 !== 0) begin errors++; $display("FAIL glitch_frameErr_count got=%0d exp=0", fcnt - f0); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = vcnt; f0 = fcnt; rxq.delete();
    @(negedge clk);
    send_frame(8'h55, 1'b0, TBIT);
    checks++; if (fcnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", fcnt - f0); end
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid_count got=%0d exp=0", vcnt - v0); end
    checks++; if (bus.dataOut !== 8'hFF) begin errors++; $display("FAIL ferr_dataOut_kept got=%h exp=ff", bus.dataOut); end
    #(40 * TCLK);
    checks++; if (fcnt - f0 !== 1 || vcnt - v0 !== 0) begin errors++; $display("FAIL ferr_break_pulses got=%0d/%0d exp=1/0", fcnt - f0, vcnt - v0); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got=%b exp=1", bus.busy); end
    bus.uartBus = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_recover_idle got=%b exp=0", bus.busy); end
    send_frame(8'h12, 1'b1, TBIT);
    repeat (4) @(negedge clk);
    checks++; if (vcnt - v0 !== 1 || bus.dataOut !== 8'h12) begin errors++; $display("FAIL ferr_next_frame got=%h cnt=%0d exp=12 cnt=1", bus.dataOut, vcnt - v0); end
  endtask

  task automatic test_reset_midframe;
    int v0, f0;
    v0 = vcnt; f0 = fcnt;
    @(negedge clk);
    fork
      send_frame(8'h81, 1'b1, TBIT);
      begin
        #(5 * TBIT + TBIT / 2);
        rst = 1'b1;
        #(TCLK);
        checks++; if (bus.dataOut !== 8'h00) begin errors++; $display("FAIL rstmid_dataOut got=%h exp=00", bus.dataOut); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.dataValid !== 1'b0 || bus.frameErr !== 1'b0) begin errors++; $display("FAIL rstmid_pulses got=%b%b exp=00", bus.dataValid, bus.frameErr); end
      end
    join
    #(2 * TCLK);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (vcnt - v0 !== 0 || fcnt - f0 !== 0) begin errors++; $display("FAIL rstmid_no_pulse got=%0d/%0d exp=0/0", vcnt - v0, fcnt - f0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after got=%b exp=0", bus.busy); end
    send_frame(8'h81, 1'b1, TBIT);
    repeat (4) @(negedge clk);
    checks++; if (vcnt - v0 !== 1 || bus.dataOut !== 8'h81) begin errors++; $display("FAIL rstmid_next_frame got=%h cnt=%0d exp=81 cnt=1", bus.dataOut, vcnt - v0); end
  endtask

  task automatic test_baud_tol;
    int v0, f0;
    int per[2];
    per[0] = (TBIT * 103) / 100;
    per[1] = (TBIT * 97) / 100;
    for (int k = 0; k < 2; k++) begin
      // Seed dataOut with a nonzero word so a stuck register is visible.
      send_frame(8'hC3, 1'b1, TBIT);
      repeat (4) @(negedge clk);
      v0 = vcnt; f0 = fcnt;
      send_frame(8'h00, 1'b1, per[k]);
      repeat (4) @(negedge clk);
      checks++; if (bus.dataOut !== 8'h00) begin errors++; $display("FAIL tol%0d_dataOut got=%h exp=00", k, bus.dataOut); end
      checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL tol%0d_valid_count got=%0d exp=1", k, vcnt - v0); end
      checks++; if (fcnt - f0 !== 0) begin errors++; $display("FAIL tol%0d_frameErr_count got=%0d exp=0", k, fcnt - f0); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.uartBus = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_midframe;
    test_baud_tol;
    checks++; if (both !== 0) begin errors++; $display("FAIL valid_and_ferr_same_cycle got=%0d exp=0", both); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
